// File: rtl/swc_rtu_rsp_buffer.sv
// Per-port RTU response buffer: captures single-cycle RTU response strobes
// into a small FIFO and presents the oldest entry to the swcore until acked.
module swc_rtu_rsp_buffer #(
  parameter int unsigned g_num_ports  = 7,
  parameter int unsigned g_prio_width = 3,
  parameter int unsigned g_depth      = 4,
  parameter int unsigned g_cnt_width  = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       rtu_valid_i,
  input  logic [g_num_ports-1:0]     rtu_dst_port_mask_i,
  input  logic                       rtu_drop_i,
  input  logic [g_prio_width-1:0]    rtu_prio_i,
  output logic                       rtu_full_o,
  output logic                       swc_rsp_valid_o,
  input  logic                       swc_rsp_ack_i,
  output logic [g_num_ports-1:0]     swc_dst_port_mask_o,
  output logic                       swc_drop_o,
  output logic [g_prio_width-1:0]    swc_prio_o,
  output logic [$clog2(g_depth):0]   level_o,
  output logic [g_cnt_width-1:0]     ovf_cnt_o
);

  localparam int unsigned c_aw = $clog2(g_depth);
  localparam int unsigned c_lw = c_aw + 1;
  localparam int unsigned c_ew = g_num_ports + 1 + g_prio_width;
  localparam logic [c_lw-1:0] c_full = c_lw'(g_depth);

  logic [c_ew-1:0]        mem [g_depth];
  logic [c_aw-1:0]        wr_ptr;
  logic [c_aw-1:0]        rd_ptr;
  logic [c_aw-1:0]        rd_ptr_nxt;
  logic [c_lw-1:0]        count;
  logic [c_lw-1:0]        count_nxt;
  logic [c_lw-1:0]        count_after_pop;
  logic [g_cnt_width-1:0] ovf_cnt;
  logic                   wr_en;
  logic                   pop;
  logic                   ovf;
  logic                   valid_q;
  logic                   full_q;
  logic [c_ew-1:0]        wr_data;
  logic [c_ew-1:0]        head_nxt;
  logic [c_ew-1:0]        head_q;

  // Write/pop decisions and next-state occupancy, head entry and pointers
  always_comb begin
    wr_data         = {rtu_dst_port_mask_i, rtu_drop_i, rtu_prio_i};
    wr_en           = rtu_valid_i && (count != c_full);
    ovf             = rtu_valid_i && (count == c_full);
    pop             = swc_rsp_ack_i && valid_q;
    rd_ptr_nxt      = rd_ptr + c_aw'(pop);
    count_after_pop = count - c_lw'(pop);
    count_nxt       = count_after_pop + c_lw'(wr_en);
    head_nxt        = '0;
    if (count_nxt != '0) begin
      // An empty-after-pop buffer that still has an entry holds only the new write
      if (count_after_pop == '0) begin
        head_nxt = wr_data;
      end else begin
        head_nxt = mem[rd_ptr_nxt];
      end
    end
  end

  // Entry storage; no reset needed since only count-qualified entries are read
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers, occupancy, registered head presentation and overflow counter
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      valid_q <= 1'b0;
      full_q  <= 1'b0;
      head_q  <= '0;
      ovf_cnt <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + c_aw'(1);
      end
      rd_ptr  <= rd_ptr_nxt;
      count   <= count_nxt;
      valid_q <= (count_nxt != '0);
      full_q  <= (count_nxt == c_full);
      head_q  <= head_nxt;
      if (ovf && (ovf_cnt != '1)) begin
        ovf_cnt <= ovf_cnt + g_cnt_width'(1);
      end
    end
  end

  assign rtu_full_o          = full_q;
  assign swc_rsp_valid_o     = valid_q;
  assign swc_dst_port_mask_o = head_q[c_ew-1 -: g_num_ports];
  assign swc_drop_o          = head_q[g_prio_width];
  assign swc_prio_o          = head_q[g_prio_width-1:0];
  assign level_o             = count;
  assign ovf_cnt_o           = ovf_cnt;

endmodule
